// File: rtl/fast_bconv_stream.sv
`default_nettype none
// ============================================================================
//  Module   : fast_bconv_stream
//  Purpose  : Streaming Fast-BConv. Converts LANES RNS integers per beat from
//             the input basis q_i to the output basis b_j:
//               c_j = sum_i ((x_i*z_i mod q_i) * y_ji) mod b_j
//             TERMS_PER_CYCLE i-terms are folded into the accumulators per
//             cycle. Valid/ready on both sides; tag/last ride with each beat.
//  Revision : 1.0  initial release
// ============================================================================
module fast_bconv_stream #(
   parameter int RES_W           = 8,
   parameter int IN_BASIS_LEN    = 5,
   parameter int OUT_BASIS_LEN   = 3,
   parameter logic [IN_BASIS_LEN-1:0][RES_W-1:0]  IN_BASIS  = {8'd19, 8'd17, 8'd13, 8'd11, 8'd7},
   parameter logic [OUT_BASIS_LEN-1:0][RES_W-1:0] OUT_BASIS = {8'd31, 8'd29, 8'd23},
   parameter logic [IN_BASIS_LEN-1:0][RES_W-1:0]  ZILUT     = {8'd8, 8'd4, 8'd7, 8'd1, 8'd5},
   parameter logic [OUT_BASIS_LEN-1:0][IN_BASIS_LEN-1:0][RES_W-1:0] YMODB = {
      {8'd29, 8'd16, 8'd9,  8'd5,  8'd30},
      {8'd23, 8'd24, 8'd18, 8'd16, 8'd21},
      {8'd20, 8'd21, 8'd8,  8'd22, 8'd5}},
   parameter int LANES           = 1,
   parameter int TERMS_PER_CYCLE = 1,
   parameter int TAG_W           = 8
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          in_valid,
   output logic                                          in_ready,
   input  logic [TAG_W-1:0]                              in_tag,
   input  logic                                          in_last,
   input  logic [LANES-1:0][IN_BASIS_LEN-1:0][RES_W-1:0]  input_RNSvec,
   output logic                                          out_valid,
   input  logic                                          out_ready,
   output logic [TAG_W-1:0]                              out_tag,
   output logic                                          out_last,
   output logic [LANES-1:0][OUT_BASIS_LEN-1:0][RES_W-1:0] output_RNSvec,
   output logic                                          busy
);

   localparam int NSTEP  = (IN_BASIS_LEN + TERMS_PER_CYCLE - 1) / TERMS_PER_CYCLE;
   localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam int IDX_W  = (IN_BASIS_LEN > 1) ? $clog2(IN_BASIS_LEN) : 1;
   localparam int WIDE_W = 2 * RES_W;

   typedef logic [RES_W-1:0]  rns_residue_t;
   typedef logic [WIDE_W-1:0] wide_rns_residue_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCALE = 2'd1,
      S_ACCUM = 2'd2,
      S_HOLD  = 2'd3
   } state_t;

   if (TERMS_PER_CYCLE < 1 || TERMS_PER_CYCLE > IN_BASIS_LEN) begin : g_bad_terms
      $fatal(1, "fast_bconv_stream: TERMS_PER_CYCLE must be in 1..IN_BASIS_LEN");
   end
   if (LANES < 1) begin : g_bad_lanes
      $fatal(1, "fast_bconv_stream: LANES must be >= 1");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $fatal(1, "fast_bconv_stream: TAG_W must be >= 1");
   end

   state_t                                           r_state;
   logic [STEP_W-1:0]                                r_step;
   logic [LANES-1:0][IN_BASIS_LEN-1:0][RES_W-1:0]    r_x;
   logic [LANES-1:0][IN_BASIS_LEN-1:0][RES_W-1:0]    r_a;
   logic [LANES-1:0][OUT_BASIS_LEN-1:0][RES_W-1:0]   r_acc;
   logic [TAG_W-1:0]                                 r_tag;
   logic                                             r_last;

   logic [LANES-1:0][IN_BASIS_LEN-1:0][RES_W-1:0]    w_scaled;
   logic [LANES-1:0][TERMS_PER_CYCLE-1:0][RES_W-1:0] w_sel_a;
   logic [OUT_BASIS_LEN-1:0][TERMS_PER_CYCLE-1:0][RES_W-1:0] w_sel_y;
   logic [TERMS_PER_CYCLE-1:0]                       w_term_en;
   logic [IDX_W-1:0]                                 w_idx;
   logic [LANES-1:0][OUT_BASIS_LEN-1:0][RES_W-1:0]   w_acc_next;
   wide_rns_residue_t                                w_scale_prod;
   wide_rns_residue_t                                w_term_prod;
   rns_residue_t                                     w_term;
   logic [RES_W:0]                                   w_sum;

   assign in_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready);
   assign busy     = (r_state != S_IDLE);

   // Pre-scale every captured residue by its CRT inverse: a = x*z mod q.
   always_comb begin
      w_scaled     = '0;
      w_scale_prod = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int i = 0; i < IN_BASIS_LEN; i++) begin
            w_scale_prod   = wide_rns_residue_t'(r_x[l][i]) * wide_rns_residue_t'(ZILUT[i]);
            w_scaled[l][i] = rns_residue_t'(w_scale_prod % wide_rns_residue_t'(IN_BASIS[i]));
         end
      end
   end

   // Pick the i-terms belonging to the current step; the last step may be partial.
   always_comb begin
      w_sel_a   = '0;
      w_sel_y   = '0;
      w_term_en = '0;
      w_idx     = '0;
      for (int k = 0; k < NSTEP; k++) begin
         for (int t = 0; t < TERMS_PER_CYCLE; t++) begin
            if ((r_step == STEP_W'(k)) && (k * TERMS_PER_CYCLE + t < IN_BASIS_LEN)) begin
               w_idx        = IDX_W'(k * TERMS_PER_CYCLE + t);
               w_term_en[t] = 1'b1;
               for (int l = 0; l < LANES; l++) begin
                  w_sel_a[l][t] = r_a[l][w_idx];
               end
               for (int j = 0; j < OUT_BASIS_LEN; j++) begin
                  w_sel_y[j][t] = YMODB[j][w_idx];
               end
            end
         end
      end
   end

   // Fold the selected terms in ascending i, reducing after each term so the
   // running sum never exceeds 2*b_j and matches a serial (acc+p) mod b_j.
   always_comb begin
      w_acc_next  = '0;
      w_term_prod = '0;
      w_term      = '0;
      w_sum       = '0;
      for (int l = 0; l < LANES; l++) begin
         for (int j = 0; j < OUT_BASIS_LEN; j++) begin
            w_sum = {1'b0, r_acc[l][j]};
            for (int t = 0; t < TERMS_PER_CYCLE; t++) begin
               if (w_term_en[t]) begin
                  w_term_prod = wide_rns_residue_t'(w_sel_a[l][t]) * wide_rns_residue_t'(w_sel_y[j][t]);
                  w_term      = rns_residue_t'(w_term_prod % wide_rns_residue_t'(OUT_BASIS[j]));
                  w_sum       = w_sum + {1'b0, w_term};
                  if (w_sum >= {1'b0, OUT_BASIS[j]}) begin
                     w_sum = w_sum - {1'b0, OUT_BASIS[j]};
                  end
               end
            end
            w_acc_next[l][j] = w_sum[RES_W-1:0];
         end
      end
   end

   // Control FSM and registered outputs; a HOLD with both handshakes goes
   // straight to SCALE so back-to-back beats see no bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_step        <= '0;
         r_x           <= '0;
         r_a           <= '0;
         r_acc         <= '0;
         r_tag         <= '0;
         r_last        <= 1'b0;
         out_valid     <= 1'b0;
         output_RNSvec <= '0;
         out_tag       <= '0;
         out_last      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_x     <= input_RNSvec;
                  r_tag   <= in_tag;
                  r_last  <= in_last;
                  r_state <= S_SCALE;
               end
            end
            S_SCALE: begin
               r_a     <= w_scaled;
               r_acc   <= '0;
               r_step  <= '0;
               r_state <= S_ACCUM;
            end
            S_ACCUM: begin
               r_acc <= w_acc_next;
               if (r_step == STEP_W'(NSTEP - 1)) begin
                  output_RNSvec <= w_acc_next;
                  out_tag       <= r_tag;
                  out_last      <= r_last;
                  out_valid     <= 1'b1;
                  r_state       <= S_HOLD;
               end else begin
                  r_step <= r_step + STEP_W'(1);
               end
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     r_x     <= input_RNSvec;
                     r_tag   <= in_tag;
                     r_last  <= in_last;
                     r_state <= S_SCALE;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
